// File: rtl/nibble_serial_subtractor_pkg.sv
// rtl/nibble_serial_subtractor_pkg.sv - shared constants and FSM encoding for the nibble-serial subtractor
package sub_pkg;

   // Width of one serial slice
   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_cla_sub_4.sv
// rtl/nibble_serial_subtractor_cla_sub_4.sv - combinational 4-bit borrow-lookahead subtract slice
module cla_sub_4
   import sub_pkg::*;
(
   input  logic [NIB_W-1:0] X,
   input  logic [NIB_W-1:0] Y,
   input  logic             Bi,
   output logic [NIB_W-1:0] Dn,
   output logic             Bo
);

   // Generate: this bit borrows on its own; propagate: an incoming borrow passes through
   logic [NIB_W-1:0] g;
   logic [NIB_W-1:0] p;
   logic [NIB_W:0]   b;

   assign g = ~X & Y;
   assign p = ~(X ^ Y);

   // Flattened lookahead so no borrow waits on the previous bit's result
   always_comb begin
      b[0] = Bi;
      b[1] = g[0] | (p[0] & Bi);
      b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Bi);
      b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Bi);
      b[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & Bi);
   end

   assign Dn = X ^ Y ^ b[NIB_W-1:0];
   assign Bo = b[NIB_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - WIDTH-bit A-B-Bin, one nibble per clock; SUB_SAT_EN enables signed saturation
module nibble_serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             Z,
   output logic             V
);

   localparam int NIBBLES = WIDTH / NIB_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             borrow_q;

   logic [NIB_W-1:0] a_nib;
   logic [NIB_W-1:0] b_nib;
   logic [NIB_W-1:0] dn;
   logic             bo;
   logic [WIDTH-1:0] raw_d;
   logic [WIDTH-1:0] res_d;
   logic             v_next;

   assign a_nib = a_q[idx*NIB_W +: NIB_W];
   assign b_nib = b_q[idx*NIB_W +: NIB_W];

   cla_sub_4 u_slice (
      .X  (a_nib),
      .Y  (b_nib),
      .Bi (borrow_q),
      .Dn (dn),
      .Bo (bo)
   );

   // Full unclamped difference as it will look once the MSB nibble lands on the final edge
   always_comb begin
      raw_d = D;
      raw_d[WIDTH-1 -: NIB_W] = dn;
   end

   assign v_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (raw_d[WIDTH-1] != a_q[WIDTH-1]);

`ifdef SUB_SAT_EN
   // On overflow the true result has A's sign, so clamp toward that end of the range
   always_comb begin
      res_d = raw_d;
      if (v_next)
         res_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   assign res_d = raw_d;
`endif

   // Handshake FSM, nibble sequencing and result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         idx       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         borrow_q  <= 1'b0;
         D         <= '0;
         Bout      <= 1'b0;
         Z         <= 1'b0;
         V         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  a_q      <= A;
                  b_q      <= B;
                  borrow_q <= Bin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               borrow_q <= bo;
               idx      <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  D         <= res_d;
                  Bout      <= bo;
                  Z         <= (res_d == '0);
                  V         <= v_next;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  D[idx*NIB_W +: NIB_W] <= dn;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - randomized self-checking bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] D;
   logic         Bout;
   logic         Z;
   logic         V;

   int errors = 0;
   int checks = 0;

   nibble_serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
      .Bout      (Bout),
      .Z         (Z),
      .V         (V)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic on unsigned and signed views of the operands
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] d, output logic bo, output logic z, output logic v);
      int          udiff;
      int          sdiff;
      logic [31:0] bits;
      udiff = int'(a) - int'(b) - int'(bin);
      sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
      bits  = udiff;
      d     = bits[W-1:0];
      bo    = (udiff < 0);
      v     = (sdiff > 32767) || (sdiff < -32768);
`ifdef SUB_SAT_EN
      if (v) d = (sdiff > 0) ? 16'h7FFF : 16'h8000;
`endif
      z     = (d == '0);
   endtask

   // One full transaction from an IDLE negedge; junk operands are pulsed while busy
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input int hold);
      logic [W-1:0] ed;
      logic         eb, ez, ev;
      int           lat;
      int           t;
      model(a, b, bin, ed, eb, ez, ev);
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_idle", in_ready, 1);
      A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 20) begin
         in_valid = 1'($urandom); A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 4);
      check("D", D, ed);
      check("Bout", Bout, eb);
      check("Z", Z, ez);
      check("V", V, ev);
      check("in_ready_done", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom); A = W'($urandom); B = W'($urandom);
         @(negedge clk);
         check("hold_D", D, ed);
         check("hold_flags", {Bout, Z, V, out_valid, in_ready}, {eb, ez, ev, 1'b1, 1'b0});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("taken_out_valid", out_valid, 0);
      check("taken_in_ready", in_ready, 1);
   endtask

   initial begin
      int acc[$];
      int t;

      // Reset state
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_D", D, 0);
      check("rst_flags", {Bout, Z, V}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_op(16'h1234, 16'h0234, 1'b0, 0);
      run_op(16'h0000, 16'h0001, 1'b0, 0);
      run_op(16'h5555, 16'h5555, 1'b0, 0);
      run_op(16'h8000, 16'h0001, 1'b0, 0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
      run_op(16'h0010, 16'h000F, 1'b1, 0);
      run_op(16'h8000, 16'h0000, 1'b1, 1);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
      run_op(16'hA5C3, 16'h3C5A, 1'b1, 5);

      // Reset on the second BUSY cycle abandons the operation
      A = 16'h1239; B = 16'h0001; Bin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_D", D, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(16'h4321, 16'h1234, 1'b0, 0);

      // Randomized operations
      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
         run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
      end

      // Back-to-back with both sides always willing
      A = 16'h0010; B = 16'h000F; Bin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (in_ready) acc.push_back(c);
         if (out_valid) begin
            check("b2b_D", D, 0);
            check("b2b_Z", Z, 1);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("b2b_accepts", acc.size() >= 3, 1);
      for (int i = 1; i < acc.size(); i++)
         check("b2b_spacing", acc[i] - acc[i-1], 6);
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("b2b_drain", in_ready, 1);
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
